// File: rtl/sign_magnitude_lut_writer_if.sv
// Lookup channel between a requester and the sign-magnitude LUT writer.
//   req_valid/req_ready : request handshake. The transfer happens when both are high.
//   a, b                : sign-magnitude operands (MSB is the sign).
//   rsp_valid           : one-cycle pulse carrying sum/overflow for an accepted request.
//   sum, overflow       : registered result. Both hold their value between responses.
// The master modport is the requester side; the slave modport is the LUT side.
interface sign_magnitude_lut_writer_if #(
  parameter int unsigned DATA_WIDTH = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] sum;
  logic                  overflow;

  modport master (
    output req_valid, a, b,
    input  req_ready, rsp_valid, sum, overflow
  );

  modport slave (
    input  req_valid, a, b,
    output req_ready, rsp_valid, sum, overflow
  );
endinterface

// File: rtl/sign_magnitude_lut_writer.sv
// Self-initialising sign-magnitude adder table.
//
// After reset, and on every start_build request, the FSM writes all 2**ADDR_WIDTH entries
// {overflow,sum} into a single-port RAM. It then serves {a,b} lookups with a one-cycle
// registered response.
//
// Ports:
//   clk         : clock, rising edge.
//   reset       : synchronous, active-high reset.
//   start_build : rebuild request. It is only acted on while serving.
//   busy        : high while the table is being built.
//   done        : one-cycle pulse when a build completes.
//   lut         : lookup channel (req_valid/req_ready/a/b in, rsp_valid/sum/overflow out).
module sign_magnitude_lut_writer #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned ADDR_WIDTH = 2 * DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start_build,
  output logic                         busy,
  output logic                         done,
  sign_magnitude_lut_writer_if.slave   lut
);

  localparam int unsigned MagW  = DATA_WIDTH - 1;
  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  typedef enum logic [0:0] {StBuild, StServe} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    done_q, done_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   sum_q, sum_d;
  logic                    ovf_q, ovf_d;

  // Single-port table: one shared address, written only in build and read only in serve.
  logic [DATA_WIDTH:0]     mem [Depth];
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic                    mem_we;
  logic [DATA_WIDTH:0]     mem_wdata;
  logic [DATA_WIDTH:0]     mem_rdata;

  // Entry generator: the counter is decoded as {a,b}.
  logic                    sa, sb, ent_sign, ent_ovf;
  logic [MagW-1:0]         ma, mb, ent_mag;
  logic [MagW:0]           mag_add;

  always_comb begin
    sa       = cnt_q[ADDR_WIDTH-1];
    ma       = cnt_q[ADDR_WIDTH-2:DATA_WIDTH];
    sb       = cnt_q[DATA_WIDTH-1];
    mb       = cnt_q[DATA_WIDTH-2:0];
    mag_add  = {1'b0, ma} + {1'b0, mb};
    ent_mag  = '0;
    ent_sign = 1'b0;
    ent_ovf  = 1'b0;
    if (sa == sb) begin
      ent_sign = sa;
      // A carry out of the magnitude field means the sum is past the largest magnitude.
      if (mag_add[MagW]) begin
        ent_mag = '1;
        ent_ovf = 1'b1;
      end else begin
        ent_mag = mag_add[MagW-1:0];
      end
    end else if (ma > mb) begin
      ent_mag  = ma - mb;
      ent_sign = sa;
    end else if (mb > ma) begin
      ent_mag  = mb - ma;
      ent_sign = sb;
    end
    // Never produce -0.
    if (ent_mag == '0) begin
      ent_sign = 1'b0;
    end
    mem_wdata = {ent_ovf, ent_sign, ent_mag};
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  assign mem_rdata = mem[mem_addr];

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    done_d        = 1'b0;
    rsp_valid_d   = 1'b0;
    sum_d         = sum_q;
    ovf_d         = ovf_q;
    mem_we        = 1'b0;
    mem_addr      = {lut.a, lut.b};
    lut.req_ready = 1'b0;
    unique case (state_q)
      StBuild: begin
        mem_we   = !reset;
        mem_addr = cnt_q;
        cnt_d    = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == '1) begin
          state_d = StServe;
          done_d  = 1'b1;
        end
      end
      StServe: begin
        lut.req_ready = !start_build;
        if (start_build) begin
          state_d = StBuild;
          cnt_d   = '0;
        end else if (lut.req_valid) begin
          rsp_valid_d    = 1'b1;
          {ovf_d, sum_d} = mem_rdata;
        end
      end
      default: begin
        state_d = StBuild;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StBuild;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      sum_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      rsp_valid_q <= rsp_valid_d;
      sum_q       <= sum_d;
      ovf_q       <= ovf_d;
    end
  end

  assign busy         = (state_q == StBuild);
  assign done         = done_q;
  assign lut.rsp_valid = rsp_valid_q;
  assign lut.sum       = sum_q;
  assign lut.overflow  = ovf_q;

endmodule

// File: doc/sign_magnitude_lut_writer.md
Name: sign_magnitude_lut_writer

Overview:
Writer-side counterpart to the ROM-based sign-magnitude adder. An FSM computes every sign-magnitude sum and writes it into an internal RAM lookup table, then serves a/b lookups from that table through a valid/ready request and a one-cycle registered response. Rebuild of the table is available on demand. Intended as the self-initialising RAM replacement for the fixed ROM table.

Parameters:
DATA_WIDTH, 4, operand/result width; MSB is sign, lower DATA_WIDTH-1 bits are magnitude.
ADDR_WIDTH, 2*DATA_WIDTH, table address width; address = {a,b}; depth 2**ADDR_WIDTH.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  synchronous, active-high reset.
start_build  input  1  request a table rebuild (sampled only in SERVE).
busy  output  1  high while the table is being built.
done  output  1  one-cycle pulse when a build completes.
req_valid  input  1  lookup request valid.
req_ready  output  1  lookup request accepted when valid and ready are both high.
a  input  DATA_WIDTH  operand A (sign-magnitude).
b  input  DATA_WIDTH  operand B (sign-magnitude).
rsp_valid  output  1  lookup result valid (one-cycle pulse per accepted request).
sum  output  DATA_WIDTH  sign-magnitude result.
overflow  output  1  magnitude saturated for this result.

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Reset values: state=BUILD, write counter=0, busy=1, done=0, rsp_valid=0, sum=0, overflow=0. Table contents are not cleared.
- Reset mid-build or mid-lookup: the build restarts at address 0 and any pending response is dropped.
- FSM states: BUILD and SERVE.
  - BUILD: each clock edge writes entry[cnt] and increments cnt.
  - The first edge after reset deasserts writes address 0.
  - The edge that writes address 2**ADDR_WIDTH-1 moves to SERVE, clears busy, and sets done for exactly one cycle. The build therefore takes 2**ADDR_WIDTH edges (256 for the default).
  - SERVE: start_build=1 moves to BUILD on the next edge, with cnt=0 and busy=1.
- Entry data is {overflow,sum}, DATA_WIDTH+1 bits, computed from the counter.
  - Operands: a=cnt[ADDR_WIDTH-1:DATA_WIDTH], b=cnt[DATA_WIDTH-1:0]. sa/sb are the signs, ma/mb the magnitudes.
  - Equal signs: mag=ma+mb, sign=sa. If mag exceeds 2**(DATA_WIDTH-1)-1, mag saturates to that maximum and overflow=1.
  - Differing signs: if ma>mb, mag=ma-mb and sign=sa. If mb>ma, mag=mb-ma and sign=sb. If ma==mb, result is +0 (sign=0). overflow=0.
  - The result is never -0. Input -0 is treated as magnitude 0 with its sign; for example 1000+1000 = 0000.
- req_ready = (state==SERVE) && !start_build, combinational. It is 0 throughout BUILD.
- Accepted request: the RAM is read at {a,b}. On the next edge sum/overflow are registered and rsp_valid=1 for one cycle. Latency is 1 cycle.
- Back-to-back requests give back-to-back responses with no bubbles.
- sum/overflow hold their last value when rsp_valid=0.
- req_valid while not ready is ignored; the requester must hold its request. No response is produced.
- A start_build in the cycle after an accepted request still delivers that response, because the read has already been captured.
- done and rsp_valid are never high in the same cycle.
- Write and read never occur in the same cycle.
- The implementation uses a single-port RAM inferred as distributed or block RAM, with synchronous write.

Test Plan:
- Release reset; count edges -> busy=1 and req_ready=0 for 256 edges; done high for exactly 1 cycle after the 256th; busy=0 afterwards.
- Lookups with one request per cycle: 0100+0001, 0100+1001, 1100+0001, 1100+1001 -> sum=0101, 0011, 1011, 1101 respectively, each with overflow=0 and rsp_valid one cycle after acceptance.
- Boundary cases: 0111+0011 -> 0111 with overflow=1; 1110+1101 -> 1111 with overflow=1; 0011+1011 -> 0000; 1000+1000 -> 0000.
- Request during BUILD (req_valid held high from reset) -> no rsp_valid until SERVE. The first response appears 1 cycle after req_ready rises and is correct.
- start_build asserted in SERVE together with req_valid -> request not accepted; busy rises the next cycle; rebuild takes 256 cycles; done pulses again; a subsequent lookup is correct.
- Assert reset at build address ~100 for 1 cycle -> busy stays 1; the build restarts and completes 256 edges after reset deasserts; rsp_valid, sum and overflow are all 0 during reset.
